evm_ballot_conditioner: RTL

Upstream front end of the vote-logging stage. It synchronises and debounces the raw mode switch and the four candidate push-buttons, then turns each physical press into a clean ballot for the logger. In voting mode a ballot is a single-cycle button vector. The vector holds every button pressed within a short collection window, so near-simultaneous presses reach the logger together and are counted as invalid. In display mode the debounced button levels pass straight through, so the logger's count selection stays stable.

---
 rtl/evm_ballot_conditioner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/evm_ballot_conditioner.sv
// Input conditioner for the vote logger: synchronises and debounces the mode switch and
// candidate buttons, then turns each voting-mode press into a single-cycle ballot vector.
module evm_ballot_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COLLECT_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES  = 32,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_raw,
    input  logic [3:0] candid_button_raw,
    output logic       mode,
    output logic [3:0] candid_button,
    output logic       busy,
    output logic       ballot_strobe
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        EMIT,
        RELEASE,
        LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(COLLECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    // Bit 4 carries the mode switch, bits 3:0 the candidate buttons.
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       stable;
    logic [CNT_W-1:0] deb_cnt [5];

    logic       stable_mode;
    logic [3:0] stable_btn;

    logic       mode_q;
    logic [3:0] disp_q;

    state_t           state, state_d;
    logic [3:0]       acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    assign stable_mode = stable[4];
    assign stable_btn  = stable[3:0];

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {mode_raw, candid_button_raw};
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    // The DEBOUNCE_CYCLES-th differing cycle flips the level.
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
            disp_q <= '0;
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            mode_q <= stable_mode;
            disp_q <= stable_btn;
            state  <= state_d;
            acc    <= acc_d;
            cnt    <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (!stable_mode && (|stable_btn)) begin
                    state_d = COLLECT;
                    acc_d   = stable_btn;
                    cnt_d   = CNT_W'(1);
                end
            end
            COLLECT: begin
                if (stable_mode) begin
                    // Mode flipped mid-window: drop the ballot without emitting it.
                    state_d = RELEASE;
                    acc_d   = '0;
                end else begin
                    acc_d = acc | stable_btn;
                    if (cnt != CNT_MAX) begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                    if (cnt >= COLLECT_LAST) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                state_d = RELEASE;
                acc_d   = '0;
            end
            RELEASE: begin
                if (~|stable_btn) begin
                    state_d = LOCKOUT;
                    cnt_d   = '0;
                end
            end
            LOCKOUT: begin
                if (cnt >= LOCK_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Display pass-through only applies while parked in IDLE; in-flight ballots finish first.
    assign mode          = mode_q;
    assign busy          = (state != IDLE);
    assign ballot_strobe = (state == EMIT);
    assign candid_button = (state == EMIT)            ? acc    :
                           (state == IDLE && mode_q)  ? disp_q : 4'b0000;

endmodule
